// File: rtl/text_write_ctrl.sv
// Command sequencer that owns the character-map RAM write port (WRITE string, FILL run, CLEAR screen).
// Optional macro TEXT_WRAP_EN: columns past COLS-1 wrap to the next row; otherwise those cells are clipped.
module text_write_ctrl #(
   parameter int         COLS       = 100,
   parameter int         ROWS       = 75,
   parameter int         ADDR_W     = 13,
   parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [6:0]        cmd_col,
   input  logic [6:0]        cmd_row,
   input  logic [6:0]        cmd_len,
   input  logic [7:0]        cmd_char,
   input  logic              chr_valid,
   input  logic [7:0]        chr_data,
   output logic              chr_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [7:0]        COLS_C   = 8'(COLS);
   localparam logic [7:0]        ROWS_C   = 8'(ROWS);
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(COLS * ROWS - 1);
   localparam logic [1:0]        OP_WRITE = 2'b00;
   localparam logic [1:0]        OP_CLEAR = 2'b10;
   localparam logic [1:0]        OP_RSVD  = 2'b11;

   typedef enum logic [2:0] {IDLE, WRITE, FILL, CLEAR, DONE, ERR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] nxt_addr;
   logic [ADDR_W-1:0] base;
   logic [7:0]        col;
   logic [6:0]        rem;
   logic [7:0]        fill_char;
   logic              drain;
   logic              bad_cmd;
   logic              in_row;

   // Linear address stepping; stepping past the last cell returns to cell 0.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST) ? '0 : a + ADDR_W'(1);
   endfunction

   assign base    = ADDR_W'(cmd_col) + ADDR_W'(COLS) * ADDR_W'(cmd_row);
   assign bad_cmd = (cmd_op == OP_RSVD) ||
                    ((cmd_op != OP_CLEAR) &&
                     (({1'b0, cmd_col} >= COLS_C) || ({1'b0, cmd_row} >= ROWS_C)));

`ifdef TEXT_WRAP_EN
   assign in_row = 1'b1;
`else
   assign in_row = (col < COLS_C);
`endif

   // After the last cell is issued, every command spends one drain cycle before DONE,
   // so done lands N+1 cycles after the first write of an unstalled N-cell command.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         chr_ready <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         nxt_addr  <= '0;
         col       <= '0;
         rem       <= '0;
         fill_char <= '0;
         drain     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  drain     <= 1'b0;
                  fill_char <= cmd_char;
                  nxt_addr  <= next_addr(base);
                  col       <= {1'b0, cmd_col} + 8'd1;
                  if (bad_cmd) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else if (cmd_op == OP_CLEAR) begin
                     state   <= CLEAR;
                     wr_en   <= 1'b1;
                     wr_addr <= '0;
                     wr_data <= CLEAR_CHAR;
                  end else if (cmd_len == 7'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (cmd_op == OP_WRITE) begin
                     state     <= WRITE;
                     chr_ready <= 1'b1;
                     rem       <= cmd_len;
                     nxt_addr  <= base;
                     col       <= {1'b0, cmd_col};
                  end else begin
                     // FILL issues its first cell straight from the accept cycle.
                     state   <= FILL;
                     rem     <= cmd_len - 7'd1;
                     wr_en   <= 1'b1;
                     wr_addr <= base;
                     wr_data <= cmd_char;
                  end
               end
            end

            WRITE: begin
               if (rem != 7'd0) begin
                  if (chr_valid) begin
                     if (in_row) begin
                        wr_en   <= 1'b1;
                        wr_addr <= nxt_addr;
                        wr_data <= chr_data;
                     end
                     nxt_addr <= next_addr(nxt_addr);
                     col      <= col + 8'd1;
                     rem      <= rem - 7'd1;
                     if (rem == 7'd1) chr_ready <= 1'b0;
                  end
               end else if (!drain) begin
                  drain <= 1'b1;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end

            FILL: begin
               if (rem != 7'd0) begin
                  if (in_row) begin
                     wr_en   <= 1'b1;
                     wr_addr <= nxt_addr;
                     wr_data <= fill_char;
                  end
                  nxt_addr <= next_addr(nxt_addr);
                  col      <= col + 8'd1;
                  rem      <= rem - 7'd1;
               end else if (!drain) begin
                  drain <= 1'b1;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end

            CLEAR: begin
               if (!drain) begin
                  if (wr_addr == LAST) begin
                     drain <= 1'b1;
                  end else begin
                     wr_en   <= 1'b1;
                     wr_addr <= wr_addr + ADDR_W'(1);
                     wr_data <= CLEAR_CHAR;
                  end
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end

            DONE, ERR: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               chr_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Bench for text_write_ctrl: table vectors, hand sequences and random commands vs a cell-list model.
// Build with TEXT_WRAP_EN defined to check the wrapping variant.
module tb_text_write_ctrl;

   localparam int         COLS       = 100;
   localparam int         ROWS       = 75;
   localparam int         ADDR_W     = 13;
   localparam int         NCELLS     = COLS * ROWS;
   localparam logic [7:0] CLEAR_CHAR = 8'h20;
`ifdef TEXT_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = 2'b00;
   logic [6:0]        cmd_col = '0;
   logic [6:0]        cmd_row = '0;
   logic [6:0]        cmd_len = '0;
   logic [7:0]        cmd_char = '0;
   logic              chr_valid = 1'b0;
   logic [7:0]        chr_data = '0;
   logic              chr_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;
   logic              err;

   int         total = 0;
   int         bad = 0;
   int         exp_addr[$];
   logic [7:0] exp_data[$];
   logic [7:0] str[$];
   int         obs_writes;
   int         obs_first;

   typedef struct {
      logic [1:0] op;
      int         col;
      int         row;
      int         len;
      logic [7:0] ch;
      int         gap;
      bit         noise;
      bit         exp_err;
      int         exp_writes;
      int         exp_first;
   } vec_t;

   vec_t tv[12];

   text_write_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .CLEAR_CHAR(CLEAR_CHAR)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_len(cmd_len), .cmd_char(cmd_char),
      .chr_valid(chr_valid), .chr_data(chr_data), .chr_ready(chr_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Expected write list: the cells a command touches, in order, from (col,row,len) arithmetic.
   task automatic build_model(input logic [1:0] op, input int col, input int row, input int len,
                              input logic [7:0] ch, output bit is_err);
      exp_addr.delete();
      exp_data.delete();
      is_err = (op == 2'b11) || (op != 2'b10 && (col >= COLS || row >= ROWS));
      if (is_err) return;
      if (op == 2'b10) begin
         for (int a = 0; a < NCELLS; a++) begin
            exp_addr.push_back(a);
            exp_data.push_back(CLEAR_CHAR);
         end
      end else begin
         for (int i = 0; i < len; i++) begin
            if (WRAP) begin
               exp_addr.push_back((row * COLS + col + i) % NCELLS);
               exp_data.push_back((op == 2'b00) ? str[i] : ch);
            end else if (col + i < COLS) begin
               exp_addr.push_back(row * COLS + col + i);
               exp_data.push_back((op == 2'b00) ? str[i] : ch);
            end
         end
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input int col, input int row, input int len,
                          input logic [7:0] ch, input int gap, input bit noise);
      bit is_err;
      bit prev_hs;
      bit hs_now;
      int r, hs, last_hs, done_r, err_r, stray, k, ncell;
      build_model(op, col, row, len, ch, is_err);
      ncell = (op == 2'b10) ? NCELLS : len;
      k = 0;
      while (!cmd_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("cmd_ready_before", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_col   = 7'(col);
      cmd_row   = 7'(row);
      cmd_len   = 7'(len);
      cmd_char  = ch;
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
      r = 1; hs = 0; last_hs = 0; done_r = -1; err_r = -1; stray = 0; prev_hs = 1'b0;
      obs_writes = 0;
      obs_first  = -1;
      while (done_r < 0 && err_r < 0 && r < 3 * ncell + 40) begin
         if (wr_en) begin
            obs_writes++;
            if (obs_first < 0) obs_first = int'(wr_addr);
            if (op == 2'b00 && !prev_hs) stray++;
            if (exp_addr.size() == 0) stray++;
            else begin
               check("wr_addr", wr_addr, exp_addr.pop_front());
               check("wr_data", wr_data, exp_data.pop_front());
            end
         end
         if (done) done_r = r;
         if (err) err_r = r;
         if (chr_ready && (op != 2'b00 || hs >= len)) stray++;
         hs_now = 1'b0;
         if (op == 2'b00 && hs < len) begin
            case (gap)
               0:       chr_valid = 1'b1;
               1:       chr_valid = (r % 2 == 0);
               default: chr_valid = 1'($urandom_range(0, 1));
            endcase
            chr_data = str[hs];
         end else begin
            chr_valid = (gap == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            chr_data  = 8'($urandom);
         end
         if (chr_valid && chr_ready && op == 2'b00 && hs < len) begin
            hs++;
            last_hs = r;
            hs_now  = 1'b1;
         end
         prev_hs   = hs_now;
         cmd_valid = noise && (exp_addr.size() > 3);
         cmd_op    = 2'b11;
         @(posedge clk); #1;
         r++;
      end
      chr_valid = 1'b0;
      cmd_valid = 1'b0;
      check("finished", (done_r >= 0 || err_r >= 0), 1);
      check("err_flag", (err_r >= 0), is_err);
      if (is_err) check("err_cycle", err_r, 1);
      else if (len == 0 && op != 2'b10) check("done_cycle", done_r, 1);
      else if (op == 2'b00) check("done_cycle", done_r, last_hs + 3);
      else check("done_cycle", done_r, ncell + 2);
      check("writes_left", exp_addr.size(), 0);
      if (op == 2'b00 && !is_err) check("bytes_used", hs, len);
      check("stray", stray, 0);
      check("busy_after", busy, 0);
      check("cmd_ready_after", cmd_ready, 1);
      check("pulse_once", (done | err), 0);
   endtask

   task automatic reset_mid_clear();
      int k;
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k = 0;
      while (!(wr_en && wr_addr == 13'd500) && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      check("clear_reached_500", wr_addr, 500);
      check("clear_data", wr_data, CLEAR_CHAR);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_chr_ready", chr_ready, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      @(posedge clk); #1;
      check("rst_stays_idle", wr_en | busy, 0);
   endtask

   initial begin
      logic [1:0] op;
      int col, row, len, nclear;

      tv[0]  = '{2'b00,  2,  1,   3, 8'h00, 0, 1'b0, 1'b0, 3, 102};
      tv[1]  = '{2'b00, 10,  5,   4, 8'h00, 1, 1'b0, 1'b0, 4, 510};
      tv[2]  = '{2'b01, 98,  0,   4, 8'h2A, 0, 1'b0, 1'b0, WRAP ? 4 : 2, 98};
      tv[3]  = '{2'b00, 100, 0,   3, 8'h00, 0, 1'b0, 1'b1, 0, -1};
      tv[4]  = '{2'b11,  0,  0,   5, 8'h00, 0, 1'b0, 1'b1, 0, -1};
      tv[5]  = '{2'b00,  0,  0,   0, 8'h00, 0, 1'b0, 1'b0, 0, -1};
      tv[6]  = '{2'b01,  5,  5,   0, 8'h55, 0, 1'b0, 1'b0, 0, -1};
      tv[7]  = '{2'b01,  0, 75,   2, 8'h55, 0, 1'b0, 1'b1, 0, -1};
      tv[8]  = '{2'b01, 99, 74,   3, 8'h78, 0, 1'b0, 1'b0, WRAP ? 3 : 1, 7499};
      tv[9]  = '{2'b00, 95,  2,  10, 8'h00, 2, 1'b0, 1'b0, WRAP ? 10 : 5, 295};
      tv[10] = '{2'b10, 120, 0,   9, 8'h00, 0, 1'b1, 1'b0, NCELLS, 0};
      tv[11] = '{2'b01,  0,  0, 127, 8'h23, 0, 1'b0, 1'b0, WRAP ? 127 : 100, 0};

      repeat (3) @(posedge clk);
      #1;
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_chr_ready", chr_ready, 0);
      check("reset_wr_en", wr_en, 0);
      check("reset_wr_addr", wr_addr, 0);
      check("reset_wr_data", wr_data, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (tv[i]) begin
         str.delete();
         for (int j = 0; j < tv[i].len; j++) str.push_back(8'(8'h41 + j));
         run_cmd(tv[i].op, tv[i].col, tv[i].row, tv[i].len, tv[i].ch, tv[i].gap, tv[i].noise);
         check("tbl_err_writes", obs_writes, tv[i].exp_writes);
         check("tbl_first_addr", obs_first, tv[i].exp_first);
      end

      reset_mid_clear();

      nclear = 0;
      for (int n = 0; n < 30; n++) begin
         op = 2'($urandom_range(0, 3));
         if (op == 2'b10 && nclear >= 1) op = 2'b01;
         if (op == 2'b10) nclear++;
         col = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99);
         row = ($urandom_range(0, 9) == 0) ? $urandom_range(75, 127) : $urandom_range(0, 74);
         len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
         str.delete();
         for (int j = 0; j < len; j++) str.push_back(8'($urandom));
         run_cmd(op, col, row, len, 8'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/text_write_ctrl.md
Name: text_write_ctrl

Overview:
Command sequencer that owns the write port of the character-map RAM in the text overlay renderer (the ready/address/letters inputs of the phrase renderer). Accepts one command at a time: write a character string, fill a run of cells with one character, or clear the whole screen. Converts (col,row) into linear cell addresses and issues one RAM write per cycle. Sits between game/menu logic and the renderer.

Parameters:
COLS, 100, characters per row
ROWS, 75, character rows (800x600 / 8x8)
ADDR_W, 13, RAM address width; COLS*ROWS must be <= 2**ADDR_W
CLEAR_CHAR, 8'h20, code written by the CLEAR command

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready
cmd_op  in  2  00 WRITE, 01 FILL, 10 CLEAR, 11 reserved (treated as error)
cmd_col  in  7  start column
cmd_row  in  7  start row
cmd_len  in  7  cell count for WRITE/FILL, 0..127
cmd_char  in  8  fill character (FILL only)
chr_valid  in  1  string byte valid (WRITE)
chr_data  in  8  string byte
chr_ready  out  1  byte accepted when chr_valid&&chr_ready
wr_en  out  1  RAM write strobe (drives renderer ready)
wr_addr  out  ADDR_W  RAM write address
wr_data  out  8  RAM write data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on command completion
err  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset: state IDLE; cmd_ready=1, chr_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0. Reset mid-command aborts immediately; unconsumed string bytes are not accepted.
- States: IDLE, WRITE, FILL, CLEAR, DONE, ERR. All outputs registered.
- IDLE: on accept, latch col,row,len,char, compute base = col + COLS*row (ADDR_W bits). Validation: cmd_op=11, or (WRITE/FILL with col>=COLS or row>=ROWS) -> ERR. CLEAR ignores col/row/len. len=0 on WRITE/FILL -> DONE directly, no writes.
- WRITE: chr_ready=1 while remaining>0. Each handshake cycle: next cycle wr_en=1, wr_addr=current address, wr_data=chr_data; address advances, remaining decrements. chr_valid low -> no write, state holds. After last byte accepted -> DONE; chr_ready deasserts the cycle after last handshake.
- FILL: one write per cycle of cmd_char, len cycles, then DONE.
- CLEAR: writes CLEAR_CHAR to addresses 0..COLS*ROWS-1 in ascending order, one per cycle (7500 cycles at defaults), then DONE.
- Latency: first wr_en one cycle after the accept/handshake; WRITE/FILL of len N with no stalls: done pulses N+1 cycles after the first write cycle.
- DONE: done=1 one cycle, -> IDLE. ERR: err=1 one cycle, no writes, -> IDLE.
- Column overflow handled per Optional Feature. Row overflow (past ROWS-1) always wraps to row 0, address 0.
- wr_en is 0 in every cycle not listed above; wr_addr/wr_data hold last value when wr_en=0.
- cmd_valid ignored while busy; chr_valid ignored outside WRITE.

Optional Feature:
TEXT_WRAP_EN. Defined: column past COLS-1 wraps to column 0 of the next row (address simply increments). Undefined: cells past column COLS-1 are clipped — WRITE still consumes remaining bytes (chr_ready stays 1) and FILL still counts cycles, but wr_en=0 for clipped cells; done timing is unchanged.

Test Plan:
- Reset then WRITE col=2,row=1,len=3, bytes 'A','B','C' back-to-back -> wr_en 3 cycles, addrs 102,103,104, data 41,42,43; done one pulse; busy low after.
- WRITE len=4 with chr_valid gapped every other cycle -> exactly 4 writes, addrs contiguous, no write in gap cycles.
- FILL col=98,row=0,len=4,char=2A: with TEXT_WRAP_EN -> addrs 98,99,100,101; without -> writes only at 98,99, done at same cycle count.
- CLEAR -> 7500 consecutive writes of 20, addrs 0..7499, then done; cmd_valid during busy ignored.
- WRITE col=100 or cmd_op=11 -> err pulse, no wr_en, cmd_ready back high next cycle; len=0 -> done, no writes.
- Assert reset mid-CLEAR at addr 500 -> next cycle wr_en=0, busy=0, cmd_ready=1, all outputs at reset values.
